// File: rtl/Purple_Jade_pkg.sv
// Shared core-wide parameters and the types exchanged between the functional units
// and the reorder buffer.
package Purple_Jade_pkg;

  localparam int ROB_ENTRY    = 8;
  localparam int NUM_WB_PORTS = 2;
  localparam int NUM_PHYS_REG = 64;
  localparam int WORD_SIZE_P  = 32;
  localparam int NUM_FLAGS    = 4;

  localparam int ROB_IDX_W  = $clog2(ROB_ENTRY);
  localparam int PHYS_REG_W = $clog2(NUM_PHYS_REG);

  // Common data bus beat broadcast by a functional unit.
  typedef struct packed {
    logic                   valid;
    logic [PHYS_REG_W-1:0]  dest;
    logic [NUM_FLAGS-1:0]   flags;
    logic [WORD_SIZE_P-1:0] result;
  } CDB_t;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_dest;
    CDB_t                 cdb;
  } rob_wb_t;

  localparam int ROB_WB_WIDTH = $bits(rob_wb_t);

  typedef struct packed {
    logic                   busy;
    logic                   done;
    logic                   w_v;
    logic [PHYS_REG_W-1:0]  reg_dest;
    logic [WORD_SIZE_P-1:0] result;
    logic [NUM_FLAGS-1:0]   flags;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: dispatch allocates at the tail, functional units mark
// entries done by index, and the head retires once done and the consumer is ready.
module reorder_buffer #(
  parameter int ROB_ENTRY    = Purple_Jade_pkg::ROB_ENTRY,
  parameter int NUM_WB_PORTS = Purple_Jade_pkg::NUM_WB_PORTS
) (
  input  logic                                              clk_i,
  input  logic                                              reset_i,
  input  logic                                              alloc_v_i,
  input  logic                                              alloc_w_v_i,
  input  logic [Purple_Jade_pkg::PHYS_REG_W-1:0]            alloc_reg_dest_i,
  output logic                                              alloc_ready_o,
  output logic [$clog2(ROB_ENTRY)-1:0]                      alloc_idx_o,
  input  Purple_Jade_pkg::rob_wb_t [NUM_WB_PORTS-1:0]       wb_i,
  output logic                                              commit_v_o,
  input  logic                                              commit_ready_i,
  output logic [$clog2(ROB_ENTRY)-1:0]                      commit_idx_o,
  output logic                                              commit_w_v_o,
  output logic [Purple_Jade_pkg::PHYS_REG_W-1:0]            commit_reg_dest_o,
  output logic [Purple_Jade_pkg::WORD_SIZE_P-1:0]           commit_result_o,
  output logic [Purple_Jade_pkg::NUM_FLAGS-1:0]             commit_flags_o,
  input  logic                                              flush_i,
  output logic                                              full_o,
  output logic                                              empty_o
);

  localparam int IDX_W = $clog2(ROB_ENTRY);
  localparam int CNT_W = IDX_W + 1;

  typedef Purple_Jade_pkg::rob_entry_t entry_t;

  entry_t             entry_q [ROB_ENTRY];
  entry_t             entry_d [ROB_ENTRY];
  logic [IDX_W-1:0]   head_q, head_d;
  logic [IDX_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_alloc;
  logic               do_retire;

  // Status comes from the registered count only, so a retire never frees a slot
  // for dispatch in the same cycle.
  assign full_o        = (count_q == CNT_W'(ROB_ENTRY));
  assign empty_o       = (count_q == '0);
  assign alloc_ready_o = ~full_o;
  assign alloc_idx_o   = tail_q;

  assign commit_v_o        = entry_q[head_q].busy & entry_q[head_q].done;
  assign commit_idx_o      = head_q;
  assign commit_w_v_o      = entry_q[head_q].w_v;
  assign commit_reg_dest_o = entry_q[head_q].reg_dest;
  assign commit_result_o   = entry_q[head_q].result;
  assign commit_flags_o    = entry_q[head_q].flags;

  assign do_alloc  = alloc_v_i & alloc_ready_o;
  assign do_retire = commit_v_o & commit_ready_i;

  // The ROB tracks completion by index only; the CDB register tag is not needed here.
  logic [NUM_WB_PORTS-1:0] wb_dest_unused;
  for (genvar gi = 0; gi < NUM_WB_PORTS; gi++) begin : g_wb_unused
    assign wb_dest_unused[gi] = ^wb_i[gi].cdb.dest;
  end

  always_comb begin
    for (int i = 0; i < ROB_ENTRY; i++) entry_d[i] = entry_q[i];
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    // Walk from the highest port down so the lowest-numbered port writes last and wins.
    for (int p = NUM_WB_PORTS - 1; p >= 0; p--) begin
      if (wb_i[p].cdb.valid && entry_q[wb_i[p].rob_dest].busy) begin
        entry_d[wb_i[p].rob_dest].done   = 1'b1;
        entry_d[wb_i[p].rob_dest].result = wb_i[p].cdb.result;
        entry_d[wb_i[p].rob_dest].flags  = wb_i[p].cdb.flags;
      end
    end

    if (do_retire) begin
      entry_d[head_q].busy = 1'b0;
      entry_d[head_q].done = 1'b0;
      head_d               = head_q + 1'b1;
    end

    if (do_alloc) begin
      entry_d[tail_q]          = '0;
      entry_d[tail_q].busy     = 1'b1;
      entry_d[tail_q].w_v      = alloc_w_v_i;
      entry_d[tail_q].reg_dest = alloc_reg_dest_i;
      tail_d                   = tail_q + 1'b1;
    end

    count_d = count_q + CNT_W'(do_alloc) - CNT_W'(do_retire);

    if (flush_i) begin
      for (int i = 0; i < ROB_ENTRY; i++) entry_d[i] = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < ROB_ENTRY; i++) entry_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < ROB_ENTRY; i++) entry_q[i] <= entry_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
